// File: rtl/stream_to_video_pkg.sv
// Shared definitions for the stream-to-video display path.
// Holds timing defaults, derived frame totals and the sync FSM state encoding.
package stream_to_video_pkg;

  // Sum of the four segments of one raster dimension.
  function automatic int unsigned raster_total(int unsigned disp, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

  localparam int unsigned DataWidthDef = 16;
  localparam int unsigned HDispDef     = 1280;
  localparam int unsigned HFpDef       = 110;
  localparam int unsigned HSyncDef     = 40;
  localparam int unsigned HBpDef       = 220;
  localparam int unsigned VDispDef     = 720;
  localparam int unsigned VFpDef       = 5;
  localparam int unsigned VSyncDef     = 5;
  localparam int unsigned VBpDef       = 20;
  localparam int unsigned CntWDef      = 12;

  localparam int unsigned HTotalDef = raster_total(HDispDef, HFpDef, HSyncDef, HBpDef);
  localparam int unsigned VTotalDef = raster_total(VDispDef, VFpDef, VSyncDef, VBpDef);

  typedef enum logic {
    StWaitSof = 1'b0,
    StRun     = 1'b1
  } sync_state_e;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator.
// Ports: clk, rst_n (async active-low), enable (0 holds counters at 0);
//        h_cnt/v_cnt current raster position, active (inside display area),
//        first (h=0,v=0), hs/vs sync levels with polarity applied.
// All outputs are combinational decodes of the counter registers.
module video_timing_gen
  import stream_to_video_pkg::*;
#(
  parameter int unsigned H_DISP = HDispDef,
  parameter int unsigned H_FP   = HFpDef,
  parameter int unsigned H_SYNC = HSyncDef,
  parameter int unsigned H_BP   = HBpDef,
  parameter int unsigned V_DISP = VDispDef,
  parameter int unsigned V_FP   = VFpDef,
  parameter int unsigned V_SYNC = VSyncDef,
  parameter int unsigned V_BP   = VBpDef,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             first,
  output logic             hs,
  output logic             vs
);

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(raster_total(H_DISP, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(raster_total(V_DISP, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] HActEnd   = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] VActEnd   = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_DISP + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (enable) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + CntOne;
      end else begin
        h_d = h_q + CntOne;
        v_d = v_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt  = h_q;
  assign v_cnt  = v_q;
  assign active = (h_q < HActEnd) && (v_q < VActEnd);
  assign first  = (h_q == '0) && (v_q == '0);
  assign hs     = ((h_q >= HSyncBeg) && (h_q < HSyncEnd)) ? HS_POL : ~HS_POL;
  assign vs     = ((v_q >= VSyncBeg) && (v_q < VSyncEnd)) ? VS_POL : ~VS_POL;

endmodule

// File: rtl/stream_to_video.sv
// Stream-to-video reader: takes SOF-marked pixels over valid/ready and replays
// them on raster timing, filling starved pixels and resyncing on misalignment.
// Ports: clk, rst_n (async active-low), enable (timing run);
//        s_valid/s_ready/s_data/s_sof input stream;
//        vo_hs/vo_vs/vo_de/vo_data registered video out;
//        frame_start/underflow/desync one-cycle status pulses.
module stream_to_video
  import stream_to_video_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = DataWidthDef,
  parameter int unsigned          H_DISP     = HDispDef,
  parameter int unsigned          H_FP       = HFpDef,
  parameter int unsigned          H_SYNC     = HSyncDef,
  parameter int unsigned          H_BP       = HBpDef,
  parameter int unsigned          V_DISP     = VDispDef,
  parameter int unsigned          V_FP       = VFpDef,
  parameter int unsigned          V_SYNC     = VSyncDef,
  parameter int unsigned          V_BP       = VBpDef,
  parameter bit                   HS_POL     = 1'b1,
  parameter bit                   VS_POL     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL      = '0,
  parameter int unsigned          CNT_W      = CntWDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic                  vo_hs,
  output logic                  vo_vs,
  output logic                  vo_de,
  output logic [DATA_WIDTH-1:0] vo_data,
  output logic                  frame_start,
  output logic                  underflow,
  output logic                  desync
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, first, hs, vs;

  video_timing_gen #(
    .H_DISP (H_DISP),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_DISP (V_DISP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .HS_POL (HS_POL),
    .VS_POL (VS_POL),
    .CNT_W  (CNT_W)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .first  (first),
    .hs     (hs),
    .vs     (vs)
  );

  sync_state_e state_q, state_d;

  logic                  ready_raw;
  logic                  hs_d, vs_d, de_d, fs_d, uf_d, ds_d;
  logic [DATA_WIDTH-1:0] data_d;

  // A beat whose SOF flag disagrees with the raster position is a misalignment.
  logic misaligned;
  assign misaligned = s_valid && (s_sof != first);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitSof;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StWaitSof;
    end else begin
      unique case (state_q)
        StWaitSof: if (s_valid && s_sof && first) state_d = StRun;
        StRun:     if (active && misaligned) state_d = StWaitSof;
        default:   state_d = StWaitSof;
      endcase
    end
  end

  always_comb begin
    ready_raw = 1'b0;
    hs_d      = ~HS_POL;
    vs_d      = ~VS_POL;
    de_d      = 1'b0;
    data_d    = '0;
    fs_d      = 1'b0;
    uf_d      = 1'b0;
    ds_d      = 1'b0;
    if (enable) begin
      hs_d = hs;
      vs_d = vs;
      de_d = active;
      unique case (state_q)
        StWaitSof: begin
          // Non-SOF beats are drained; an SOF beat waits for the raster origin.
          ready_raw = !s_sof || first;
          if (active) data_d = FILL;
          if (s_valid && s_sof && first) begin
            data_d = s_data;
            fs_d   = 1'b1;
          end
        end
        StRun: begin
          ready_raw = active && !(s_sof && !first);
          if (active) begin
            if (!s_valid) begin
              data_d = FILL;
              uf_d   = 1'b1;
            end else if (misaligned) begin
              data_d = FILL;
              ds_d   = 1'b1;
            end else begin
              data_d = s_data;
              fs_d   = first;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Counters sit at the raster origin during reset, so gate ready explicitly.
  assign s_ready = ready_raw && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo_hs       <= ~HS_POL;
      vo_vs       <= ~VS_POL;
      vo_de       <= 1'b0;
      vo_data     <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      desync      <= 1'b0;
    end else begin
      vo_hs       <= hs_d;
      vo_vs       <= vs_d;
      vo_de       <= de_d;
      vo_data     <= data_d;
      frame_start <= fs_d;
      underflow   <= uf_d;
      desync      <= ds_d;
    end
  end

  origin_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
    first |-> ((h_cnt == '0) && (v_cnt == '0)));

endmodule
